bcd_score_engine: RTL and testbench
===================================

// Module: bcd_score_engine
// PURPOSE
//  Parametrised multi-digit BCD score keeper for the game datapath. Accepts
//  multi-digit BCD increments through a valid/ready handshake and adds them one
//  digit per cycle. Keeps a best-score register and drives registered 4-bit digit
//  codes, with leading-zero blanking and a lost message, to the display multiplexer.
// PARAMETERS
//  N_DIGITS    4        score/best width in BCD digits (2..8)
//  AMT_DIGITS  2        increment width in BCD digits (1..N_DIGITS)
//  SATURATE    1        1: clamp at all-9s on overflow; 0: wrap modulo 10^N_DIGITS
//  BLANK_CODE  4'hF     digit code the display decoder renders as blank
//  MSG         16'hD1ED packed lost-message codes, 4*N_DIGITS bits, digit0 in [3:0]
// PORTS
//  clk          in   1              clock
//  reset        in   1              synchronous, active-high
//  inc_valid    in   1              increment request
//  inc_ready    out  1              engine idle and able to accept
//  inc_amt      in   4*AMT_DIGITS   BCD increment, digit0 in [3:0]
//  clear_score  in   1              zero score (best kept)
//  lost         in   1              game-over level
//  show_best    in   1              display best instead of score
//  score_bcd    out  4*N_DIGITS     committed score
//  best_bcd     out  4*N_DIGITS     best score
//  done         out  1              1-cycle pulse: new score committed
//  overflow     out  1              sticky: carry out of top digit occurred
//  disp_digits  out  4*N_DIGITS     digit codes for display, digit0 in [3:0]
// BEHAVIOUR
//  Reset: score_bcd=0, best_bcd=0, done=0, overflow=0, FSM=IDLE, inc_ready=1,
//   disp_digits = BLANK_CODE in every digit except digit0=0.
//  FSM IDLE -> ADD -> FIN -> IDLE. inc_ready = (state==IDLE) && !lost.
//  Accept edge E0 (inc_valid && inc_ready): latch inc_amt; digits >9 are clamped
//   to 9; digits above AMT_DIGITS are 0. Copy score into a shadow register.
//  ADD: N_DIGITS cycles, digit i on cycle i: s = shadow[i] + amt[i] + carry;
//   if s>9 then digit = s-10 and carry=1, else digit = s and carry=0. carry0 = 0.
//  FIN: if the final carry is set, set overflow. With SATURATE=1, commit all-9s;
//   otherwise commit the shadow register. score_bcd changes only at this commit.
//  The commit edge is E0+N_DIGITS+1. New score_bcd and done=1 are visible in the
//   following cycle, and inc_ready=1 in that same cycle.
//  Back-to-back requests: minimum spacing is N_DIGITS+2 cycles. inc_valid is
//   ignored while inc_ready=0, and no request is queued.
//  clear_score: highest priority after reset. Next edge: score=0, overflow=0,
//   FSM=IDLE, any in-flight add is aborted with no done pulse. best_bcd unchanged.
//   inc_valid in the same cycle is not accepted.
//  lost: registered internally. On its rising edge, if score_bcd > best_bcd
//   (unsigned compare of the packed BCD), then best_bcd <= score_bcd, taking
//   effect on the next edge. An add in flight at the lost rise completes first;
//   the compare then uses the committed value at FIN. No new adds while lost=1.
//  Display source: lost -> MSG (no blanking); else show_best -> best_bcd;
//   else score_bcd.
//  Blanking: scanning from the top digit down, leading zero digits become
//   BLANK_CODE. digit0 is never blanked.
//  disp_digits is registered: it reflects a source change 1 cycle later.
// TESTING
//  1 Reset, then 3 accepted incs of 16'h0001 -> score 0003;
//    disp_digits = F,F,F,3 (top..digit0); each done exactly N_DIGITS+2 cycles
//    after its accept edge.
//  2 Score 0999, inc 0x01 -> 1000: carry ripples through all digits;
//    disp_digits = 1,0,0,0; overflow stays 0.
//  3 Score 9995, inc 0x07: SATURATE=1 -> 9999 with overflow=1;
//    SATURATE=0 -> 0002 with overflow=1.
//  4 inc_valid held during ADD -> inc_ready=0 and no second accept; clear_score
//    mid-ADD -> score 0000, no done pulse, inc_ready=1 on the next cycle.
//  5 Score 0042, best 0017, lost rises -> best 0042 and disp_digits = D,1,E,D;
//    a later game with score 0030 and lost -> best stays 0042.
//  6 show_best=1 with best 0042 -> disp F,F,4,2; inc_amt 8'hA3 is treated as 93;
//    N_DIGITS=6 build repeats tests 1-3.

Source files
------------

// File: rtl/bcd_score_engine.sv
// Multi-digit BCD score keeper: serial digit-per-cycle adder, best-score tracking and a
// registered display feed with leading-zero blanking and a lost message.
module bcd_score_engine #(
  parameter int unsigned          N_DIGITS   = 4,
  parameter int unsigned          AMT_DIGITS = 2,
  parameter int unsigned          SATURATE   = 1,
  parameter logic [3:0]           BLANK_CODE = 4'hF,
  parameter logic [4*N_DIGITS-1:0] MSG       = 16'hD1ED
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc_valid,
  output logic                    inc_ready,
  input  logic [4*AMT_DIGITS-1:0] inc_amt,
  input  logic                    clear_score,
  input  logic                    lost,
  input  logic                    show_best,
  output logic [4*N_DIGITS-1:0]   score_bcd,
  output logic [4*N_DIGITS-1:0]   best_bcd,
  output logic                    done,
  output logic                    overflow,
  output logic [4*N_DIGITS-1:0]   disp_digits
);

  localparam int unsigned W  = 4 * N_DIGITS;
  localparam int unsigned IW = $clog2(N_DIGITS + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAdd  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]    state_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  shadow_q;
  logic [W-1:0]  amt_q;
  logic [W-1:0]  score_q;
  logic [W-1:0]  best_q;
  logic          done_q;
  logic          overflow_q;
  logic          lost_q;
  logic          cmp_pend_q;
  logic [W-1:0]  disp_q;

  logic          accept;
  logic [W-1:0]  amt_in;
  logic [4:0]    sum;
  logic [4:0]    sum_adj;
  logic          sum_hi;
  logic [3:0]    sum_digit;
  logic [W-1:0]  disp_src;
  logic [W-1:0]  disp_d;
  logic          blank;

  assign inc_ready   = (state_q == StIdle) && !lost;
  assign accept      = inc_valid && inc_ready && !clear_score;
  assign score_bcd   = score_q;
  assign best_bcd    = best_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign disp_digits = disp_q;

  // Non-BCD increment digits clamp to 9; digits beyond the increment width are zero.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_amt
    if (g < AMT_DIGITS) begin : g_used
      assign amt_in[4*g +: 4] = (inc_amt[4*g +: 4] > 4'd9) ? 4'd9 : inc_amt[4*g +: 4];
    end else begin : g_zero
      assign amt_in[4*g +: 4] = 4'd0;
    end
  end

  always_comb begin
    sum       = {1'b0, shadow_q[4*idx_q +: 4]} + {1'b0, amt_q[4*idx_q +: 4]} + {4'd0, carry_q};
    sum_adj   = sum - 5'd10;
    sum_hi    = (sum > 5'd9);
    sum_digit = sum_hi ? sum_adj[3:0] : sum[3:0];
  end

  always_comb begin
    disp_src = lost ? MSG : (show_best ? best_q : score_q);
    disp_d   = disp_src;
    blank    = !lost;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (blank && (disp_src[4*i +: 4] == 4'd0)) begin
        disp_d[4*i +: 4] = BLANK_CODE;
      end else begin
        blank = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      shadow_q   <= '0;
      amt_q      <= '0;
      score_q    <= '0;
      best_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      lost_q     <= 1'b0;
      cmp_pend_q <= 1'b0;
      disp_q     <= {{(N_DIGITS-1){BLANK_CODE}}, 4'h0};
    end else begin
      lost_q <= lost;
      disp_q <= disp_d;
      done_q <= 1'b0;

      // Best-score compare waits for the FSM to be idle so an in-flight add commits first.
      if (lost && !lost_q) begin
        cmp_pend_q <= 1'b1;
      end else if (cmp_pend_q && (state_q == StIdle)) begin
        if (score_q > best_q) best_q <= score_q;
        cmp_pend_q <= 1'b0;
      end

      if (clear_score) begin
        score_q    <= '0;
        overflow_q <= 1'b0;
        state_q    <= StIdle;
        idx_q      <= '0;
        carry_q    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (accept) begin
              amt_q    <= amt_in;
              shadow_q <= score_q;
              idx_q    <= '0;
              carry_q  <= 1'b0;
              state_q  <= StAdd;
            end
          end
          StAdd: begin
            shadow_q[4*idx_q +: 4] <= sum_digit;
            carry_q                <= sum_hi;
            if (idx_q == IW'(N_DIGITS - 1)) begin
              state_q <= StFin;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StFin: begin
            if (carry_q) overflow_q <= 1'b1;
            score_q <= (carry_q && (SATURATE != 0)) ? {N_DIGITS{4'h9}} : shadow_q;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_score_engine.sv
// Directed bench driving three engines in parallel: 4-digit saturating, 4-digit wrapping
// and 6-digit saturating, with hand-computed expected values.
module tb_bcd_score_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        inc_valid;
  logic [7:0]  inc_amt;
  logic        clear_score;
  logic        lost;
  logic        show_best;

  logic        ready4, readyw, ready6;
  logic [15:0] score4, best4, disp4;
  logic [15:0] scorew, bestw, dispw;
  logic [23:0] score6, best6, disp6;
  logic        done4, donew, done6;
  logic        ovf4, ovfw, ovf6;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_score_engine #(.N_DIGITS(4), .AMT_DIGITS(2), .SATURATE(1)) u_dut4 (
    .clk(clk), .reset(reset), .inc_valid(inc_valid), .inc_ready(ready4), .inc_amt(inc_amt),
    .clear_score(clear_score), .lost(lost), .show_best(show_best), .score_bcd(score4),
    .best_bcd(best4), .done(done4), .overflow(ovf4), .disp_digits(disp4)
  );

  bcd_score_engine #(.N_DIGITS(4), .AMT_DIGITS(2), .SATURATE(0)) u_dutw (
    .clk(clk), .reset(reset), .inc_valid(inc_valid), .inc_ready(readyw), .inc_amt(inc_amt),
    .clear_score(clear_score), .lost(lost), .show_best(show_best), .score_bcd(scorew),
    .best_bcd(bestw), .done(donew), .overflow(ovfw), .disp_digits(dispw)
  );

  bcd_score_engine #(.N_DIGITS(6), .AMT_DIGITS(2), .SATURATE(1), .MSG(24'h00D1ED)) u_dut6 (
    .clk(clk), .reset(reset), .inc_valid(inc_valid), .inc_ready(ready6), .inc_amt(inc_amt),
    .clear_score(clear_score), .lost(lost), .show_best(show_best), .score_bcd(score6),
    .best_bcd(best6), .done(done6), .overflow(ovf6), .disp_digits(disp6)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready4 && readyw && ready6) && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check_val("ready_timeout", 64'({ready4, readyw, ready6}), 64'h7);
  endtask

  // Accept cycle counts as cycle 0: done is seen after edge E0+N+1, i.e. N+2 cycles on.
  task automatic do_inc(input logic [7:0] amt);
    wait_ready();
    inc_amt   = amt;
    inc_valid = 1'b1;
    step();
    inc_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_val("done4", 64'(done4), 64'(k == 5));
      check_val("donew", 64'(donew), 64'(k == 5));
      check_val("done6", 64'(done6), 64'(k == 7));
    end
  endtask

  task automatic do_clear();
    clear_score = 1'b1;
    step();
    clear_score = 1'b0;
  endtask

  task automatic check_scores(input string tag, input logic [15:0] e4, input logic [15:0] ew,
                              input logic [23:0] e6);
    check_val({tag, "_s4"}, 64'(score4), 64'(e4));
    check_val({tag, "_sw"}, 64'(scorew), 64'(ew));
    check_val({tag, "_s6"}, 64'(score6), 64'(e6));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;
    reset = 1'b1; inc_valid = 1'b0; inc_amt = 8'h00;
    clear_score = 1'b0; lost = 1'b0; show_best = 1'b0;
    repeat (3) step();
    check_scores("rst", 16'h0000, 16'h0000, 24'h000000);
    check_val("rst_best4", 64'(best4), 64'h0);
    check_val("rst_done4", 64'(done4), 64'h0);
    check_val("rst_ovf4", 64'(ovf4), 64'h0);
    check_val("rst_ready4", 64'(ready4), 64'h1);
    check_val("rst_disp4", 64'(disp4), 64'hFFF0);
    check_val("rst_disp6", 64'(disp6), 64'hFFFFF0);
    reset = 1'b0;
    step();

    // Three unit increments
    repeat (3) do_inc(8'h01);
    check_scores("t1", 16'h0003, 16'h0003, 24'h000003);
    check_val("t1_disp4", 64'(disp4), 64'hFFF3);
    check_val("t1_disp6", 64'(disp6), 64'hFFFFF3);

    // Ripple carry 0999 -> 1000
    do_clear();
    repeat (10) do_inc(8'h99);
    do_inc(8'h09);
    check_scores("t2a", 16'h0999, 16'h0999, 24'h000999);
    check_val("t2a_disp4", 64'(disp4), 64'hF999);
    check_val("t2a_disp6", 64'(disp6), 64'hFFF999);
    do_inc(8'h01);
    check_scores("t2b", 16'h1000, 16'h1000, 24'h001000);
    check_val("t2b_disp4", 64'(disp4), 64'h1000);
    check_val("t2b_disp6", 64'(disp6), 64'hFF1000);
    check_val("t2b_ovf4", 64'(ovf4), 64'h0);
    check_val("t2b_ovfw", 64'(ovfw), 64'h0);

    // Overflow: 9995 + 7
    repeat (90) do_inc(8'h99);
    do_inc(8'h85);
    check_scores("t3a", 16'h9995, 16'h9995, 24'h009995);
    do_inc(8'h07);
    check_scores("t3b", 16'h9999, 16'h0002, 24'h010002);
    check_val("t3_ovf4", 64'(ovf4), 64'h1);
    check_val("t3_ovfw", 64'(ovfw), 64'h1);
    check_val("t3_ovf6", 64'(ovf6), 64'h0);
    check_val("t3_disp4", 64'(disp4), 64'h9999);
    check_val("t3_dispw", 64'(dispw), 64'hFFF2);
    check_val("t3_disp6", 64'(disp6), 64'hF10002);

    // inc_valid held through ADD: one accept only
    do_clear();
    check_val("t4_clr_ovf4", 64'(ovf4), 64'h0);
    check_val("t4_clr_ovfw", 64'(ovfw), 64'h0);
    check_scores("t4_clr", 16'h0000, 16'h0000, 24'h000000);
    wait_ready();
    inc_amt   = 8'h05;
    inc_valid = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      check_val("t4_ready4", 64'(ready4), 64'h0);
      check_val("t4_ready6", 64'(ready6), 64'h0);
    end
    inc_valid = 1'b0;
    repeat (6) step();
    check_scores("t4_hold", 16'h0005, 16'h0005, 24'h000005);

    // clear_score mid-ADD aborts with no done pulse
    wait_ready();
    inc_amt   = 8'h22;
    inc_valid = 1'b1;
    step();
    inc_valid = 1'b0;
    step();
    clear_score = 1'b1;
    step();
    clear_score = 1'b0;
    check_scores("t4_abort", 16'h0000, 16'h0000, 24'h000000);
    check_val("t4_abort_ready4", 64'(ready4), 64'h1);
    check_val("t4_abort_ready6", 64'(ready6), 64'h1);
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      saw_done = saw_done | done4 | donew | done6;
      step();
    end
    check_val("t4_no_done", 64'(saw_done), 64'h0);
    check_scores("t4_after", 16'h0000, 16'h0000, 24'h000000);

    // Best-score tracking and lost message
    do_inc(8'h17);
    lost = 1'b1;
    repeat (3) step();
    check_val("t5_best17_4", 64'(best4), 64'h0017);
    check_val("t5_best17_6", 64'(best6), 64'h000017);
    lost = 1'b0;
    do_clear();
    do_inc(8'h42);
    lost = 1'b1;
    repeat (3) step();
    check_val("t5_best42_4", 64'(best4), 64'h0042);
    check_val("t5_best42_w", 64'(bestw), 64'h0042);
    check_val("t5_best42_6", 64'(best6), 64'h000042);
    check_val("t5_msg4", 64'(disp4), 64'hD1ED);
    check_val("t5_msg6", 64'(disp6), 64'h00D1ED);
    check_val("t5_lost_ready", 64'(ready4), 64'h0);
    lost = 1'b0;
    do_clear();
    do_inc(8'h30);
    lost = 1'b1;
    repeat (3) step();
    check_val("t5_keep4", 64'(best4), 64'h0042);
    check_val("t5_keep6", 64'(best6), 64'h000042);
    lost = 1'b0;
    step();

    // show_best display, then non-BCD amount clamp
    show_best = 1'b1;
    repeat (2) step();
    check_val("t6_best_disp4", 64'(disp4), 64'hFF42);
    check_val("t6_best_disp6", 64'(disp6), 64'hFFFF42);
    show_best = 1'b0;
    do_clear();
    do_inc(8'hA3);
    check_scores("t6_clamp", 16'h0093, 16'h0093, 24'h000093);
    check_val("t6_clamp_disp4", 64'(disp4), 64'hFF93);

    // lost rising mid-ADD: add completes, then best takes the committed value
    do_clear();
    wait_ready();
    inc_amt   = 8'h55;
    inc_valid = 1'b1;
    step();
    inc_valid = 1'b0;
    step();
    lost = 1'b1;
    repeat (10) step();
    check_scores("t7_inflight", 16'h0055, 16'h0055, 24'h000055);
    check_val("t7_best4", 64'(best4), 64'h0055);
    check_val("t7_best6", 64'(best6), 64'h000055);
    // Requests ignored while lost
    inc_amt   = 8'h01;
    inc_valid = 1'b1;
    repeat (10) step();
    inc_valid = 1'b0;
    check_scores("t7_lost_block", 16'h0055, 16'h0055, 24'h000055);
    lost = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
